// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-entry valid/ready holding register, framing-error and overrun pulses
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, BRK = 3'd4;

    logic          rx_meta_q, rxs_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          done, take, tick;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done    = 1'b0;
        ferr_d  = 1'b0;
        tick    = cnt_q == LAST;
        case (state_q)
            IDLE: begin
                state_d = rxs_q ? IDLE : START;
                cnt_d   = '0;
            end
            START: begin
                cnt_d   = cnt_q == HALF ? '0 : cnt_q + CW'(1);
                bit_d   = 3'd0;
                state_d = cnt_q != HALF ? START : (rxs_q ? IDLE : DATA);
            end
            DATA: begin
                cnt_d = tick ? '0 : cnt_q + CW'(1);
                if (tick) begin
                    shift_d[bit_q] = rxs_q;
                    bit_d          = bit_q + 3'd1;
                    state_d        = bit_q == 3'd7 ? STOP : DATA;
                end
            end
            STOP: begin
                cnt_d   = tick ? '0 : cnt_q + CW'(1);
                done    = tick & rxs_q;
                ferr_d  = tick & ~rxs_q;
                state_d = !tick ? STOP : (rxs_q ? IDLE : BRK);
            end
            BRK:     state_d = rxs_q ? IDLE : BRK;
            default: state_d = IDLE;
        endcase
        // A completed byte may land in the same cycle the consumer drains the old one
        take    = ~valid_q | data_ready;
        data_d  = done & take ? shift_q : data_q;
        valid_d = (done & take) | (valid_q & ~data_ready);
        ovr_d   = done & ~take;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the existing uart_tx; shares its CLKS_PER_BIT bit-timing convention so the two loop back directly.
- Synchronises the asynchronous rx line, detects and validates the start bit, and samples each bit at mid-bit.
- Presents each received byte through a one-entry holding register with a valid/ready handshake.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per UART bit (10 MHz / 115200); legal range >= 4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk
- data_out  output  8  received byte held in the buffer
- data_valid  output  1  buffer holds an unread byte
- data_ready  input  1  consumer accepts the byte when data_valid & data_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte completed while buffer full and not being read

Behaviour:
- Reset values:
  - Synchroniser flops = 1.
  - State = IDLE, bit counter = 0, cycle counter = 0.
  - data_out = 0x00, data_valid = 0, frame_err = 0, overrun = 0.
- Synchroniser: rx passes through 2 flops; "rxs" below is the second flop output. All line decisions use rxs only.
- HALF = (CLKS_PER_BIT-1)/2 (integer division). The cycle counter is wide enough for CLKS_PER_BIT-1.
- IDLE:
  - rxs==0 -> START, cycle counter cleared.
- START:
  - Count up to HALF.
  - At count==HALF: rxs==0 -> DATA with counter=0 and bit index=0; rxs==1 -> IDLE (glitch rejected, no flags).
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rxs into shift bit [bit index]. Data is LSB first.
  - After bit 7 is sampled -> STOP. Otherwise increment bit index.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rxs.
  - rxs==1: byte complete; go to IDLE in the same cycle.
  - rxs==0: pulse frame_err on the next cycle and discard the byte. Go to BREAK.
- BREAK:
  - Wait while rxs==0; rxs==1 -> IDLE. A held-low line produces exactly one frame_err.
- Byte complete (stop sampled high), registered on the next edge:
  - data_valid==0, or data_valid & data_ready that same cycle -> data_out = new byte, data_valid = 1.
  - Otherwise the buffer keeps the old byte, the new byte is dropped, and overrun pulses for one cycle.
- Handshake:
  - data_valid clears on the edge after any cycle where data_valid & data_ready and no byte completes.
  - data_out is stable while data_valid=1.
  - data_ready while data_valid=0 has no effect.
- Latency: the rx falling edge to data_valid rise is 2 + HALF + 9*CLKS_PER_BIT + 1 clocks (±1 for edge phase).
- The receiver resynchronises on every start bit; there is no dependence on the previous frame's timing.
- rst asserted mid-frame: return to IDLE immediately, drop the partial byte, clear the buffer and all flags. After release, a frame already in progress is only picked up at its next falling edge.
- Back-to-back frames with no idle time between stop and start are received correctly. IDLE reacts on the cycle after completion.

Test Plan:
- CLKS_PER_BIT=8. Drive 0xA5 8N1 via a uart_tx-compatible bit model, data_ready=1 -> one data_valid cycle, data_out=0xA5, no flags.
- Three back-to-back frames 0x00, 0xFF, 0x3C, data_ready=0, reading after each -> each byte appears in order; data_valid holds until data_ready pulses.
- Two frames 0x11 then 0x22 with data_ready=0 throughout -> data_out stays 0x11, one overrun pulse at the second completion. Then pulse data_ready -> data_valid=0.
- Frame 0x55 with stop bit driven low, then rx held low for 40 cycles, then idle, then frame 0x99 -> exactly one frame_err, no data_valid for 0x55, 0x99 received.
- Low glitch of 2 cycles (< HALF) on idle rx -> no data_valid, no frame_err, state returns to IDLE. The following frame 0x0F is received.
- Assert rst during bit 4 of frame 0xC3, release, send 0x81 -> nothing for 0xC3, outputs at reset values during reset, 0x81 received cleanly.
